// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings, board geometry and FSM states for cell_reveal
package game_pkg;

  localparam int MINES_EASY   = 10;
  localparam int MINES_MEDIUM = 15;
  localparam int MINES_HARD   = 40;

  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  localparam logic [3:0] CELL_FLAG   = 4'd9;
  localparam logic [3:0] CELL_MINE   = 4'd10;
  localparam logic [3:0] CELL_HIDDEN = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    FLAG_WR,
    MINE_WR,
    SCAN,
    WRITE,
    OVER
  } state_e;

  function automatic logic [4:0] board_size(input logic [1:0] lvl);
    case (lvl)
      LVL_HARD:   board_size = 5'd16;
      LVL_MEDIUM: board_size = 5'd10;
      default:    board_size = 5'd8;
    endcase
  endfunction

  function automatic logic [8:0] safe_cells(input logic [1:0] lvl);
    case (lvl)
      LVL_HARD:   safe_cells = 9'(16 * 16 - MINES_HARD);
      LVL_MEDIUM: safe_cells = 9'(10 * 10 - MINES_MEDIUM);
      default:    safe_cells = 9'(8 * 8 - MINES_EASY);
    endcase
  endfunction

  // Scan order: top row left to right, middle row left/right, bottom row left to right.
  function automatic logic signed [5:0] nb_dx(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3, 3'd5: nb_dx = -6'sd1;
      3'd1, 3'd6:       nb_dx = 6'sd0;
      default:          nb_dx = 6'sd1;
    endcase
  endfunction

  function automatic logic signed [5:0] nb_dy(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: nb_dy = -6'sd1;
      3'd3, 3'd4:       nb_dy = 6'sd0;
      default:          nb_dy = 6'sd1;
    endcase
  endfunction

endpackage

// File: rtl/board_bitmap.sv
// rtl/board_bitmap.sv - 16x16 single-bit cell memory with set/toggle write
module board_bitmap (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  logic       wr_toggle,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic       rd_data
);

  logic [255:0] bits_q;
  logic [255:0] bits_d;

  always_comb begin
    bits_d = bits_q;
    if (clr) begin
      bits_d = '0;
    end else if (wr_en) begin
      bits_d[{wr_y, wr_x}] = wr_toggle ? ~bits_q[{wr_y, wr_x}] : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign rd_data = bits_q[{rd_y, rd_x}];

endmodule

// File: rtl/cell_reveal.sv
// rtl/cell_reveal.sv - click handling, 8-neighbour mine scan and win/loss tracking
module cell_reveal
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] button_ind_x_in,
  input  logic [4:0] button_ind_y_in,
  input  logic       explode,
  input  logic       mark_flag,
  input  logic       click_valid,
  input  logic [1:0] level,
  input  logic       new_game,
  output logic [4:0] mine_rd_x,
  output logic [4:0] mine_rd_y,
  input  logic       mine_rd_data,
  output logic       cell_wr_en,
  output logic [4:0] cell_wr_x,
  output logic [4:0] cell_wr_y,
  output logic [3:0] cell_wr_state,
  output logic       busy,
  output logic       game_lost,
  output logic       game_won,
  output logic [8:0] revealed_cnt
);

  state_e      state_q, state_d;
  logic [4:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  lvl_q, lvl_d;
  logic [2:0]  step_q, step_d;
  logic [3:0]  count_q, count_d;
  logic [8:0]  revealed_cnt_q, revealed_cnt_d;
  logic        game_lost_q, game_lost_d;
  logic        game_won_q, game_won_d;

  logic        rev_rd, flag_rd;
  logic        rev_set, flag_tgl;
  logic [3:0]  bm_x, bm_y;
  logic [4:0]  click_size, cur_size;
  logic        click_in_board;
  logic signed [5:0] nb_x, nb_y;
  logic        nb_in;

  // In IDLE the bitmaps are addressed by the incoming click; afterwards by the latched cell.
  assign bm_x = (state_q == IDLE) ? button_ind_x_in[3:0] : x_q[3:0];
  assign bm_y = (state_q == IDLE) ? button_ind_y_in[3:0] : y_q[3:0];

  board_bitmap u_revealed (
    .clk       (clk),
    .rst       (rst),
    .clr       (new_game),
    .wr_en     (rev_set),
    .wr_toggle (1'b0),
    .wr_x      (bm_x),
    .wr_y      (bm_y),
    .rd_x      (bm_x),
    .rd_y      (bm_y),
    .rd_data   (rev_rd)
  );

  board_bitmap u_flagged (
    .clk       (clk),
    .rst       (rst),
    .clr       (new_game),
    .wr_en     (flag_tgl),
    .wr_toggle (1'b1),
    .wr_x      (bm_x),
    .wr_y      (bm_y),
    .rd_x      (bm_x),
    .rd_y      (bm_y),
    .rd_data   (flag_rd)
  );

  always_comb begin
    click_size     = board_size(level);
    cur_size       = board_size(lvl_q);
    click_in_board = (button_ind_x_in < click_size) && (button_ind_y_in < click_size);
    nb_x  = $signed({1'b0, x_q}) + nb_dx(step_q);
    nb_y  = $signed({1'b0, y_q}) + nb_dy(step_q);
    nb_in = !nb_x[5] && !nb_y[5] && (nb_x[4:0] < cur_size) && (nb_y[4:0] < cur_size);
  end

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    lvl_d          = lvl_q;
    step_d         = step_q;
    count_d        = count_q;
    revealed_cnt_d = revealed_cnt_q;
    game_lost_d    = game_lost_q;
    game_won_d     = game_won_q;
    flag_tgl       = 1'b0;
    rev_set        = 1'b0;
    mine_rd_x      = 5'd0;
    mine_rd_y      = 5'd0;
    cell_wr_en     = 1'b0;
    cell_wr_x      = 5'd0;
    cell_wr_y      = 5'd0;
    cell_wr_state  = 4'd0;
    busy           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (click_valid && click_in_board) begin
          x_d   = button_ind_x_in;
          y_d   = button_ind_y_in;
          lvl_d = level;
          if (mark_flag) begin
            if (!rev_rd) begin
              flag_tgl = 1'b1;
              state_d  = FLAG_WR;
            end
          end else if (!flag_rd && !rev_rd) begin
            if (explode) begin
              game_lost_d = 1'b1;
              state_d     = MINE_WR;
            end else begin
              step_d  = 3'd0;
              count_d = 4'd0;
              state_d = SCAN;
            end
          end
        end
      end
      FLAG_WR: begin
        cell_wr_en    = 1'b1;
        cell_wr_x     = x_q;
        cell_wr_y     = y_q;
        cell_wr_state = flag_rd ? CELL_FLAG : CELL_HIDDEN;
        state_d       = IDLE;
      end
      MINE_WR: begin
        cell_wr_en    = 1'b1;
        cell_wr_x     = x_q;
        cell_wr_y     = y_q;
        cell_wr_state = CELL_MINE;
        state_d       = OVER;
      end
      SCAN: begin
        busy      = 1'b1;
        mine_rd_x = nb_in ? nb_x[4:0] : x_q;
        mine_rd_y = nb_in ? nb_y[4:0] : y_q;
        count_d   = count_q + {3'b000, nb_in & mine_rd_data};
        step_d    = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy           = 1'b1;
        cell_wr_en     = 1'b1;
        cell_wr_x      = x_q;
        cell_wr_y      = y_q;
        cell_wr_state  = count_q;
        rev_set        = 1'b1;
        revealed_cnt_d = revealed_cnt_q + 9'd1;
        if (revealed_cnt_d == safe_cells(lvl_q)) begin
          game_won_d = 1'b1;
          state_d    = OVER;
        end else begin
          state_d = IDLE;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (new_game) begin
      state_d        = IDLE;
      x_d            = 5'd0;
      y_d            = 5'd0;
      lvl_d          = 2'd0;
      step_d         = 3'd0;
      count_d        = 4'd0;
      revealed_cnt_d = 9'd0;
      game_lost_d    = 1'b0;
      game_won_d     = 1'b0;
      flag_tgl       = 1'b0;
      rev_set        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      x_q            <= 5'd0;
      y_q            <= 5'd0;
      lvl_q          <= 2'd0;
      step_q         <= 3'd0;
      count_q        <= 4'd0;
      revealed_cnt_q <= 9'd0;
      game_lost_q    <= 1'b0;
      game_won_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      lvl_q          <= lvl_d;
      step_q         <= step_d;
      count_q        <= count_d;
      revealed_cnt_q <= revealed_cnt_d;
      game_lost_q    <= game_lost_d;
      game_won_q     <= game_won_d;
    end
  end

  assign game_lost    = game_lost_q;
  assign game_won     = game_won_q;
  assign revealed_cnt = revealed_cnt_q;

endmodule

// File: tb/tb_cell_reveal.sv
// tb/tb_cell_reveal.sv - self-checking bench for cell_reveal
module tb_cell_reveal;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] bx, by;
  logic       explode, mark_flag, click_valid, new_game;
  logic [1:0] level;
  logic [4:0] mine_rd_x, mine_rd_y;
  logic       mine_rd_data;
  logic       cell_wr_en;
  logic [4:0] cell_wr_x, cell_wr_y;
  logic [3:0] cell_wr_state;
  logic       busy, game_lost, game_won;
  logic [8:0] revealed_cnt;

  int vectors = 0;
  int miscompares = 0;

  bit mine_map [16][16];
  bit m_rev [16][16];
  bit m_flag [16][16];
  int m_cnt, m_lvl;
  bit m_lost, m_won;

  always #5 clk = ~clk;

  assign mine_rd_data = (mine_rd_x < 5'd16 && mine_rd_y < 5'd16) ?
                        mine_map[mine_rd_y[3:0]][mine_rd_x[3:0]] : 1'b0;

  cell_reveal dut (
    .clk             (clk),
    .rst             (rst),
    .button_ind_x_in (bx),
    .button_ind_y_in (by),
    .explode         (explode),
    .mark_flag       (mark_flag),
    .click_valid     (click_valid),
    .level           (level),
    .new_game        (new_game),
    .mine_rd_x       (mine_rd_x),
    .mine_rd_y       (mine_rd_y),
    .mine_rd_data    (mine_rd_data),
    .cell_wr_en      (cell_wr_en),
    .cell_wr_x       (cell_wr_x),
    .cell_wr_y       (cell_wr_y),
    .cell_wr_state   (cell_wr_state),
    .busy            (busy),
    .game_lost       (game_lost),
    .game_won        (game_won),
    .revealed_cnt    (revealed_cnt)
  );

  function automatic int size_of(input int lvl);
    return (lvl == 3) ? 16 : (lvl == 2) ? 10 : 8;
  endfunction

  function automatic int mines_of(input int lvl);
    return (lvl == 3) ? 40 : (lvl == 2) ? 15 : 10;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void clear_map();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        mine_map[y][x] = 1'b0;
  endfunction

  function automatic void place_mines(input int n, input int sz);
    int placed = 0;
    int x, y;
    clear_map();
    while (placed < n) begin
      x = $urandom_range(0, sz - 1);
      y = $urandom_range(0, sz - 1);
      if (!mine_map[y][x]) begin
        mine_map[y][x] = 1'b1;
        placed++;
      end
    end
  endfunction

  function automatic void model_clear(input int lvl);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        m_rev[y][x]  = 1'b0;
        m_flag[y][x] = 1'b0;
      end
    m_cnt = 0; m_lost = 1'b0; m_won = 1'b0; m_lvl = lvl;
  endfunction

  // Game rules stated directly: returns write offset (0 = no write) and written state.
  function automatic void model_click(input int x, input int y, input bit ex, input bit mf,
                                      output int off, output int st);
    int sz = size_of(m_lvl);
    off = 0; st = 0;
    if (m_lost || m_won || x >= sz || y >= sz) return;
    if (mf) begin
      if (!m_rev[y][x]) begin
        m_flag[y][x] = !m_flag[y][x];
        off = 1;
        st = m_flag[y][x] ? 9 : 15;
      end
      return;
    end
    if (m_flag[y][x] || m_rev[y][x]) return;
    if (ex) begin
      m_lost = 1'b1; off = 1; st = 10;
      return;
    end
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < sz && y + dy >= 0 && y + dy < sz)
          st += int'(mine_map[y + dy][x + dx]);
    m_rev[y][x] = 1'b1;
    m_cnt++;
    if (m_cnt == sz * sz - mines_of(m_lvl)) m_won = 1'b1;
    off = 9;
  endfunction

  task automatic do_new_game(input int lvl);
    level = 2'(lvl);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear(lvl);
  endtask

  task automatic apply(input int x, input int y, input bit ex, input bit mf,
                       input int eoff, input int est);
    int nwr = 0, woff = 0, wst = 0, wx = 0, wy = 0, nbusy = 0, bad_rd = 0;
    int sz = size_of(m_lvl);
    bx = 5'(x); by = 5'(y); explode = ex; mark_flag = mf; click_valid = 1'b1;
    tick();
    click_valid = 1'b0; explode = 1'b0; mark_flag = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (busy) begin
        nbusy++;
        if (int'(mine_rd_x) >= sz || int'(mine_rd_y) >= sz) bad_rd++;
      end
      if (cell_wr_en) begin
        nwr++; woff = c; wst = int'(cell_wr_state);
        wx = int'(cell_wr_x); wy = int'(cell_wr_y);
      end
      if (c < 11) tick();
    end
    chk("wr_count", nwr, int'(eoff != 0));
    if (eoff != 0) begin
      chk("wr_latency", woff, eoff);
      chk("wr_state", wst, est);
      chk("wr_x", wx, x);
      chk("wr_y", wy, y);
    end
    chk("busy_cycles", nbusy, (eoff == 9) ? 9 : 0);
    chk("rd_in_board", bad_rd, 0);
    chk("revealed_cnt", int'(revealed_cnt), m_cnt);
    chk("game_lost", int'(game_lost), int'(m_lost));
    chk("game_won", int'(game_won), int'(m_won));
  endtask

  typedef struct {
    int x;
    int y;
    bit ex;
    bit mf;
    int off;
    int st;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int eo, es, nwr, woff, wx, sz, x, y, lv;
    bit ex, mf;

    rst = 1'b1; bx = '0; by = '0; explode = 1'b0; mark_flag = 1'b0;
    click_valid = 1'b0; new_game = 1'b0; level = 2'd0;
    clear_map();
    model_clear(0);
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(cell_wr_en), 0);
    chk("rst_lost", int'(game_lost), 0);
    chk("rst_won", int'(game_won), 0);
    chk("rst_revealed", int'(revealed_cnt), 0);
    rst = 1'b0;
    tick();

    // Easy board, mines at (x,y) = (0,1),(1,0),(1,1)
    mine_map[1][0] = 1'b1; mine_map[0][1] = 1'b1; mine_map[1][1] = 1'b1;
    tbl[0]  = '{3, 3, 1'b0, 1'b0, 9, 0};
    tbl[1]  = '{0, 0, 1'b0, 1'b0, 9, 3};
    tbl[2]  = '{5, 2, 1'b0, 1'b1, 1, 9};
    tbl[3]  = '{5, 2, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{5, 2, 1'b0, 1'b1, 1, 15};
    tbl[5]  = '{2, 2, 1'b0, 1'b0, 9, 1};
    tbl[6]  = '{3, 3, 1'b0, 1'b0, 0, 0};
    tbl[7]  = '{8, 0, 1'b0, 1'b0, 0, 0};
    tbl[8]  = '{2, 1, 1'b0, 1'b0, 9, 2};
    tbl[9]  = '{2, 2, 1'b0, 1'b1, 0, 0};
    tbl[10] = '{4, 4, 1'b1, 1'b0, 1, 10};
    tbl[11] = '{6, 6, 1'b0, 1'b0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      model_click(tbl[i].x, tbl[i].y, tbl[i].ex, tbl[i].mf, eo, es);
      apply(tbl[i].x, tbl[i].y, tbl[i].ex, tbl[i].mf, tbl[i].off, tbl[i].st);
    end
    chk("tbl_revealed", int'(revealed_cnt), 4);
    chk("tbl_lost", int'(game_lost), 1);

    do_new_game(0);
    chk("ng_revealed", int'(revealed_cnt), 0);
    chk("ng_lost", int'(game_lost), 0);
    model_click(5, 2, 1'b0, 1'b1, eo, es);
    apply(5, 2, 1'b0, 1'b1, 1, 9);

    // Medium: mines fill row 9 and half of row 8; reveal all 85 safe cells
    do_new_game(2);
    clear_map();
    for (int i = 0; i < 10; i++) mine_map[9][i] = 1'b1;
    for (int i = 0; i < 5; i++) mine_map[8][i] = 1'b1;
    model_click(12, 3, 1'b0, 1'b0, eo, es);
    apply(12, 3, 1'b0, 1'b0, 0, 0);
    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < 10; xx++)
        if (!mine_map[yy][xx]) begin
          model_click(xx, yy, 1'b0, 1'b0, eo, es);
          apply(xx, yy, 1'b0, 1'b0, eo, es);
        end
    chk("med_won", int'(game_won), 1);
    chk("med_revealed", int'(revealed_cnt), 85);

    // click_valid held through a scan: only the first click lands
    do_new_game(0);
    clear_map();
    model_click(3, 3, 1'b0, 1'b0, eo, es);
    bx = 5'd3; by = 5'd3; click_valid = 1'b1;
    tick();
    bx = 5'd4; by = 5'd4;
    nwr = 0; woff = 0; wx = 0;
    for (int c = 1; c <= 12; c++) begin
      if (cell_wr_en) begin nwr++; woff = c; wx = int'(cell_wr_x); end
      if (c == 9) click_valid = 1'b0;
      tick();
    end
    chk("held_wr_count", nwr, 1);
    chk("held_wr_latency", woff, 9);
    chk("held_wr_x", wx, 3);
    chk("held_revealed", int'(revealed_cnt), 1);

    // Reset during scan cycle 4
    do_new_game(0);
    bx = 5'd2; by = 5'd2; click_valid = 1'b1;
    tick();
    click_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_wr_en", int'(cell_wr_en), 0);
    chk("rst_mid_rd_x", int'(mine_rd_x), 0);
    nwr = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (cell_wr_en) nwr++;
    end
    chk("rst_mid_no_write", nwr, 0);
    chk("rst_mid_revealed", int'(revealed_cnt), 0);
    rst = 1'b0;
    model_clear(0);
    tick();

    // Randomized games against the reference model
    do_new_game(3);
    place_mines(40, 16);
    for (int i = 0; i < 150; i++) begin
      if (m_lost || m_won) begin
        lv = $urandom_range(0, 3);
        do_new_game(lv);
        place_mines(mines_of(lv), size_of(lv));
      end
      sz = size_of(m_lvl);
      x = $urandom_range(0, sz + 1);
      y = $urandom_range(0, sz + 1);
      mf = ($urandom_range(0, 3) == 0);
      ex = (x < sz && y < sz) ? mine_map[y][x] : 1'($urandom_range(0, 1));
      model_click(x, y, ex, mf, eo, es);
      apply(x, y, ex, mf, eo, es);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
